lift_car_sequencer: RTL and testbench

- Cycle-level model and sequencer of the lift car. Consumes motion and direction decisions from the request ALU, and produces the one-hot floor position and door-open signal that the ALU consumes.
- Times inter-floor travel, door dwell, and door closing, and enforces door/motion interlock.
- Sits between main_alu_block and the top level, closing the ALU's feedback loop.

---
 rtl/lift_car_sequencer.sv | 124 ++++++++++++
 tb/tb_lift_car_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lift_car_sequencer.sv
// Lift car model: times travel, door dwell and door closing, and reports the car's floor
// and door state to the request ALU. No input reaches an output combinationally.
module lift_car_sequencer #(
  parameter int unsigned N_FLOORS          = 8,
  parameter int unsigned TRAVEL_CYCLES     = 16,
  parameter int unsigned DOOR_OPEN_CYCLES  = 32,
  parameter int unsigned DOOR_CLOSE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_motion,
  input  logic                        i_direction,
  input  logic                        i_has_rqst_at_stopped_flr,
  input  logic                        i_door_hold,
  output logic [N_FLOORS-1:0]         o_flr_pos,
  output logic [$clog2(N_FLOORS)-1:0] o_curr_flr,
  output logic                        o_door_open,
  output logic                        o_moving,
  output logic                        o_limit_err
);

  localparam int unsigned FlrW = $clog2(N_FLOORS);
  localparam int unsigned MaxA = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ?
                                 TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int unsigned MaxCycles = (MaxA > DOOR_CLOSE_CYCLES) ? MaxA : DOOR_CLOSE_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCycles + 1);

  localparam logic [TimerW-1:0] TravelLoad = TimerW'(TRAVEL_CYCLES - 1);
  localparam logic [TimerW-1:0] OpenLoad   = TimerW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] CloseLoad  = TimerW'(DOOR_CLOSE_CYCLES - 1);
  localparam logic [FlrW-1:0]   TopFloor   = FlrW'(N_FLOORS - 1);

  typedef enum logic [1:0] {StStopped, StMoving, StDoorOpen, StDoorClose} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [FlrW-1:0]   floor_q, floor_d;
  logic              dir_q, dir_d;
  logic              limit_q, limit_d;
  logic              expired;

  assign expired = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StStopped;
      timer_q <= '0;
      floor_q <= '0;
      dir_q   <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    limit_d = limit_q;
    unique case (state_q)
      StStopped: begin
        if (i_has_rqst_at_stopped_flr || i_door_hold) begin
          state_d = StDoorOpen;
          timer_d = OpenLoad;
        end else if (i_motion) begin
          dir_d = i_direction;
          if ((i_direction && floor_q == TopFloor) || (!i_direction && floor_q == '0)) begin
            limit_d = 1'b1;
          end else begin
            state_d = StMoving;
            timer_d = TravelLoad;
          end
        end
      end
      StMoving: begin
        // Direction is the one latched at departure; inputs are ignored while travelling.
        if (expired) begin
          state_d = StStopped;
          floor_d = dir_q ? floor_q + FlrW'(1) : floor_q - FlrW'(1);
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StDoorOpen: begin
        if (i_door_hold) begin
          timer_d = OpenLoad;
        end else if (expired) begin
          state_d = StDoorClose;
          timer_d = CloseLoad;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StDoorClose: begin
        if (i_door_hold) begin
          state_d = StDoorOpen;
          timer_d = OpenLoad;
        end else if (expired) begin
          state_d = StStopped;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = StStopped;
    endcase
  end

  always_comb begin
    o_flr_pos = '0;
    if (state_q != StMoving) o_flr_pos[floor_q] = 1'b1;
  end

  assign o_curr_flr  = floor_q;
  assign o_door_open = (state_q == StDoorOpen);
  assign o_moving    = (state_q == StMoving);
  assign o_limit_err = limit_q;

endmodule

// File: tb/tb_lift_car_sequencer.sv
// Directed bench for lift_car_sequencer: a short vector table from reset plus
// hand-written sequences for travel, door timing, limits and mid-travel reset.
module tb_lift_car_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_motion, i_direction, i_has_rqst_at_stopped_flr, i_door_hold;
  logic [7:0] o_flr_pos;
  logic [2:0] o_curr_flr;
  logic       o_door_open, o_moving, o_limit_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lift_car_sequencer #(
    .N_FLOORS         (8),
    .TRAVEL_CYCLES    (16),
    .DOOR_OPEN_CYCLES (32),
    .DOOR_CLOSE_CYCLES(4)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .i_motion                 (i_motion),
    .i_direction              (i_direction),
    .i_has_rqst_at_stopped_flr(i_has_rqst_at_stopped_flr),
    .i_door_hold              (i_door_hold),
    .o_flr_pos                (o_flr_pos),
    .o_curr_flr               (o_curr_flr),
    .o_door_open              (o_door_open),
    .o_moving                 (o_moving),
    .o_limit_err              (o_limit_err)
  );

  typedef struct {
    logic       motion, dir, rqst, hold;
    logic [7:0] pos;
    logic [2:0] curr;
    logic       door, moving, lim;
  } vec_t;

  vec_t vecs[4];

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic move(input logic d);
    i_motion    = 1'b1;
    i_direction = d;
    step();
    i_motion = 1'b0;
    check("move_start", {31'd0, o_moving}, 32'd1);
    for (int k = 0; k < 40 && o_moving; k++) step();
    check("move_done", {31'd0, o_moving}, 32'd0);
  endtask

  int cnt;
  logic bad;

  initial begin
    i_motion = 0; i_direction = 0; i_has_rqst_at_stopped_flr = 0; i_door_hold = 0;
    //         mot dir rq  hd  pos    cur door mov lim
    vecs[0] = '{0, 0, 0, 0, 8'h01, 3'd0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 8'h01, 3'd0, 0, 0, 1};  // down at floor 0: limit error
    vecs[2] = '{0, 1, 0, 0, 8'h01, 3'd0, 0, 0, 1};  // error is sticky
    vecs[3] = '{1, 1, 1, 0, 8'h01, 3'd0, 1, 0, 1};  // door request beats motion

    do_reset();
    repeat (3) step();
    check("rst_pos", {24'd0, o_flr_pos}, 32'h01);
    check("rst_curr", {29'd0, o_curr_flr}, 32'd0);
    check("rst_door", {31'd0, o_door_open}, 32'd0);
    check("rst_moving", {31'd0, o_moving}, 32'd0);
    check("rst_lim", {31'd0, o_limit_err}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      i_motion = vecs[i].motion; i_direction = vecs[i].dir;
      i_has_rqst_at_stopped_flr = vecs[i].rqst; i_door_hold = vecs[i].hold;
      step();
      check($sformatf("vec%0d_pos", i), {24'd0, o_flr_pos}, {24'd0, vecs[i].pos});
      check($sformatf("vec%0d_curr", i), {29'd0, o_curr_flr}, {29'd0, vecs[i].curr});
      check($sformatf("vec%0d_door", i), {31'd0, o_door_open}, {31'd0, vecs[i].door});
      check($sformatf("vec%0d_mov", i), {31'd0, o_moving}, {31'd0, vecs[i].moving});
      check($sformatf("vec%0d_lim", i), {31'd0, o_limit_err}, {31'd0, vecs[i].lim});
    end
    i_motion = 0; i_has_rqst_at_stopped_flr = 0;
    do_reset();
    check("rst2_lim", {31'd0, o_limit_err}, 32'd0);

    // Travel 0 -> 1, toggling direction mid-flight.
    i_motion = 1; i_direction = 1;
    step();
    i_motion = 0;
    check("travel_curr", {29'd0, o_curr_flr}, 32'd0);
    cnt = 0; bad = 0;
    while (o_moving && cnt < 40) begin
      if (o_flr_pos != 8'h00) bad = 1;
      cnt++;
      i_direction = ~i_direction;
      step();
    end
    check("travel_cycles", cnt, 32'd16);
    check("travel_pos_zero", {31'd0, bad}, 32'd0);
    check("arrive_pos", {24'd0, o_flr_pos}, 32'h02);
    check("arrive_curr", {29'd0, o_curr_flr}, 32'd1);

    // Door cycle at floor 1 with motion held high throughout.
    i_direction = 1; i_motion = 1; i_has_rqst_at_stopped_flr = 1;
    step();
    i_has_rqst_at_stopped_flr = 0;
    cnt = 0; bad = 0;
    while (o_door_open && cnt < 100) begin
      if (o_moving) bad = 1;
      cnt++;
      step();
    end
    check("dwell_cycles", cnt, 32'd32);
    cnt = 0;
    while (!o_door_open && !o_moving && cnt < 100) begin
      cnt++;
      step();
    end
    check("close_plus_stop", cnt, 32'd5);
    check("interlock", {31'd0, bad}, 32'd0);
    i_motion = 0;
    for (int k = 0; k < 40 && o_moving; k++) step();
    check("floor2_pos", {24'd0, o_flr_pos}, 32'h04);

    // Hold during 0-based dwell cycles 30..39 stretches the dwell to 72.
    i_has_rqst_at_stopped_flr = 1;
    step();
    i_has_rqst_at_stopped_flr = 0;
    cnt = 0;
    while (o_door_open && cnt < 200) begin
      i_door_hold = (cnt >= 30 && cnt <= 39);
      cnt++;
      step();
    end
    i_door_hold = 0;
    check("held_dwell", cnt, 32'd72);
    step();  // second DOOR_CLOSE cycle
    check("closing_door", {31'd0, o_door_open}, 32'd0);
    i_door_hold = 1;
    step();
    i_door_hold = 0;
    check("reopen", {31'd0, o_door_open}, 32'd1);
    cnt = 0;
    while (o_door_open && cnt < 100) begin
      cnt++;
      step();
    end
    check("reopen_dwell", cnt, 32'd32);
    repeat (5) step();
    check("back_stopped", {24'd0, o_flr_pos}, 32'h04);

    // Up to the top floor, then request up.
    repeat (5) move(1'b1);
    check("top_pos", {24'd0, o_flr_pos}, 32'h80);
    check("top_curr", {29'd0, o_curr_flr}, 32'd7);
    i_motion = 1; i_direction = 1;
    step();
    i_motion = 0;
    check("top_lim", {31'd0, o_limit_err}, 32'd1);
    check("top_no_move", {31'd0, o_moving}, 32'd0);
    step();
    check("top_lim_sticky", {31'd0, o_limit_err}, 32'd1);
    check("top_pos_kept", {24'd0, o_flr_pos}, 32'h80);
    do_reset();
    check("lim_cleared", {31'd0, o_limit_err}, 32'd0);

    // Reset in cycle 5 of travel from floor 3 to 4.
    repeat (3) move(1'b1);
    check("floor3_pos", {24'd0, o_flr_pos}, 32'h08);
    i_motion = 1; i_direction = 1;
    step();
    i_motion = 0;
    repeat (4) step();
    check("mid_moving", {31'd0, o_moving}, 32'd1);
    reset = 1;
    step();
    check("mid_rst_pos", {24'd0, o_flr_pos}, 32'h01);
    check("mid_rst_curr", {29'd0, o_curr_flr}, 32'd0);
    check("mid_rst_mov", {31'd0, o_moving}, 32'd0);
    check("mid_rst_door", {31'd0, o_door_open}, 32'd0);
    reset = 0;
    move(1'b1);
    check("resume_pos", {24'd0, o_flr_pos}, 32'h02);
    check("resume_curr", {29'd0, o_curr_flr}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
